// File: rtl/ntt_stage_controller_pkg.sv
// Shared NTT types: controller state encoding, per-stage address constants, twiddle modes.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package ntt_stage_controller_pkg;

   // Controller states; one stage is READ -> DRAIN -> SWAP, the run ends with DONE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_SWAP  = 3'd3,
      ST_DONE  = 3'd4
   } ntt_state_t;

   // Twiddle addressing modes, selected by where log_m sits relative to the core count.
   typedef enum logic [1:0] {
      MODE_INTRA = 2'd0,
      MODE_EDGE  = 2'd1,
      MODE_INTER = 2'd2
   } ntt_mode_t;

   localparam int ADDRS_PER_STAGE = 512;
   localparam int ADDR_W          = 9;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDRS_PER_STAGE - 1);

   // Below the core count the butterflies stay inside one core, at it they straddle, above it they cross.
   function automatic ntt_mode_t ntt_mode(input logic [3:0] lm, input logic [3:0] log_core_count);
      ntt_mode_t m;
      if (lm < log_core_count) begin
         m = MODE_INTRA;
      end else if (lm == log_core_count) begin
         m = MODE_EDGE;
      end else begin
         m = MODE_INTER;
      end
      return m;
   endfunction

endpackage

// File: rtl/ntt_write_delay.sv
// Write-side delay line: carries a read's valid flag and address forward to its result write.
// Latency: exactly PIPE_LAT cycles from issue to write.
// Backpressure: none; shifts every cycle, cleared by reset so no stale strobe survives an abort.
module ntt_write_delay
   import ntt_stage_controller_pkg::*;
#(
   parameter int PIPE_LAT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_vld,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              write_vld,
   output logic [ADDR_W-1:0] write_addr
);

   logic [PIPE_LAT-1:0]             vld_sr;
   logic [PIPE_LAT-1:0][ADDR_W-1:0] addr_sr;

   // Shift valid and address one slot per cycle; idle slots carry a zero address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr  <= '0;
         addr_sr <= '0;
      end else begin
         vld_sr[0]  <= issue_vld;
         addr_sr[0] <= issue_vld ? issue_addr : '0;
         for (int k = 1; k < PIPE_LAT; k++) begin
            vld_sr[k]  <= vld_sr[k-1];
            addr_sr[k] <= addr_sr[k-1];
         end
      end
   end

   assign write_vld  = vld_sr[PIPE_LAT-1];
   assign write_addr = addr_sr[PIPE_LAT-1];

endmodule

// File: rtl/ntt_stage_controller.sv
// NTT stage sequencer: walks all stages, issuing 512 reads each, and ping-pongs the RAM banks.
// Latency: start -> first read 1 cycle; each stage 512 + PIPE_LAT + 1 cycles; writes trail reads by PIPE_LAT.
// Backpressure: none; free-running once started, start is ignored while busy.
module ntt_stage_controller
   import ntt_stage_controller_pkg::*;
#(
   parameter int LOG_CORE_COUNT = 5,
   parameter int LAST_STAGE     = 11,
   parameter int PIPE_LAT       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [3:0]  log_m,
   output logic [9:0]  i,
   output logic [8:0]  read_address,
   output logic [1:0]  mode,
   output logic        read_select,
   output logic        write_select,
   output logic        upper_write_enable,
   output logic        lower_write_enable,
   output logic [8:0]  upper_write_address,
   output logic [8:0]  lower_write_address,
   output logic        busy,
   output logic        done
);

   ntt_state_t        state, state_nxt;
   logic [3:0]        log_m_q, log_m_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [3:0]        drain_q, drain_nxt;
   logic              rsel_q, rsel_nxt;
   logic              busy_q, done_q;
   logic              wr_vld;
   logic [ADDR_W-1:0] wr_addr;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-datapath decode; read address is forced to zero outside READ.
   always_comb begin
      state_nxt = state;
      log_m_nxt = log_m_q;
      addr_nxt  = '0;
      drain_nxt = drain_q;
      rsel_nxt  = rsel_q;
      case (state)
         ST_IDLE: begin
            log_m_nxt = '0;
            if (start) begin
               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (addr_q == ADDR_LAST) begin
               state_nxt = ST_DRAIN;
               drain_nxt = '0;
            end else begin
               addr_nxt = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == 4'(PIPE_LAT - 1)) begin
               state_nxt = ST_SWAP;
            end else begin
               drain_nxt = drain_q + 1'b1;
            end
         end
         ST_SWAP: begin
            rsel_nxt = ~rsel_q;
            if (log_m_q == 4'(LAST_STAGE)) begin
               state_nxt = ST_DONE;
            end else begin
               log_m_nxt = log_m_q + 1'b1;
               state_nxt = ST_READ;
            end
         end
         ST_DONE: begin
            log_m_nxt = '0;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            log_m_nxt = '0;
         end
      endcase
   end

   // Datapath registers; busy/done are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_m_q <= '0;
         addr_q  <= '0;
         drain_q <= '0;
         rsel_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         log_m_q <= log_m_nxt;
         addr_q  <= addr_nxt;
         drain_q <= drain_nxt;
         rsel_q  <= rsel_nxt;
         busy_q  <= (state_nxt != ST_IDLE);
         done_q  <= (state_nxt == ST_DONE);
      end
   end

   // The read presented this cycle enters the delay line and returns as the write PIPE_LAT later.
   ntt_write_delay #(
      .PIPE_LAT (PIPE_LAT)
   ) u_write_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_vld  (state == ST_READ),
      .issue_addr (addr_q),
      .write_vld  (wr_vld),
      .write_addr (wr_addr)
   );

   assign log_m               = log_m_q;
   assign read_address        = addr_q;
   assign i                   = {1'b0, addr_q};
   assign mode                = ntt_mode(log_m_q, 4'(LOG_CORE_COUNT));
   assign read_select         = rsel_q;
   assign write_select        = ~rsel_q;
   assign upper_write_enable  = wr_vld;
   assign lower_write_enable  = wr_vld;
   assign upper_write_address = wr_addr;
   assign lower_write_address = wr_addr;
   assign busy                = busy_q;
   assign done                = done_q;

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Bench for ntt_stage_controller: default instance plus a PIPE_LAT=1 instance, checked per cycle.
// Latency: reference model predicts every output from cycles elapsed since start.
// Backpressure: n/a.
module tb_ntt_stage_controller;

   logic clk = 1'b0;
   logic rst_n;
   logic start, start1;

   logic [3:0] log_m, log_m1;
   logic [9:0] i, i1;
   logic [8:0] read_address, read_address1;
   logic [1:0] mode, mode1;
   logic       read_select, read_select1, write_select, write_select1;
   logic       upper_write_enable, upper_write_enable1, lower_write_enable, lower_write_enable1;
   logic [8:0] upper_write_address, upper_write_address1, lower_write_address, lower_write_address1;
   logic       busy, busy1, done, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ntt_stage_controller dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .log_m(log_m), .i(i), .read_address(read_address), .mode(mode),
      .read_select(read_select), .write_select(write_select),
      .upper_write_enable(upper_write_enable), .lower_write_enable(lower_write_enable),
      .upper_write_address(upper_write_address), .lower_write_address(lower_write_address),
      .busy(busy), .done(done)
   );

   ntt_stage_controller #(.PIPE_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .log_m(log_m1), .i(i1), .read_address(read_address1), .mode(mode1),
      .read_select(read_select1), .write_select(write_select1),
      .upper_write_enable(upper_write_enable1), .lower_write_enable(lower_write_enable1),
      .upper_write_address(upper_write_address1), .lower_write_address(lower_write_address1),
      .busy(busy1), .done(done1)
   );

   // Vector layout: busy[48] done[47] log_m[46:43] mode[42:41] i[40:31] ra[30:22]
   // rsel[21] wsel[20] uwe[19] lwe[18] uwa[17:9] lwa[8:0]
   function automatic logic [48:0] obs(input int which);
      if (which == 0)
         return {busy, done, log_m, mode, i, read_address, read_select, write_select,
                 upper_write_enable, lower_write_enable, upper_write_address, lower_write_address};
      else
         return {busy1, done1, log_m1, mode1, i1, read_address1, read_select1, write_select1,
                 upper_write_enable1, lower_write_enable1, upper_write_address1, lower_write_address1};
   endfunction

   // Expected outputs k cycles after the cycle start was presented (k<1: idle).
   function automatic logic [48:0] model(input int k, input int p);
      int s_len, kk, stage, off;
      logic b, d, rs, we;
      logic [3:0] lm;
      logic [1:0] md;
      logic [8:0] ra, wa;
      s_len = 512 + p + 1;
      kk = k - 1;
      b = 0; d = 0; rs = 0; we = 0; lm = 0; ra = 0; wa = 0;
      if (k >= 1 && kk < 12 * s_len) begin
         stage = kk / s_len;
         off   = kk % s_len;
         b  = 1;
         lm = 4'(stage);
         rs = (stage % 2) == 1;
         if (off < 512) ra = 9'(off);
         if (off >= p && off < 512 + p) begin
            we = 1;
            wa = 9'(off - p);
         end
      end else if (k >= 1 && kk == 12 * s_len) begin
         b = 1; d = 1; lm = 4'd11;
      end
      md = (lm < 4'd5) ? 2'd0 : (lm == 4'd5) ? 2'd1 : 2'd2;
      return {b, d, lm, md, 1'b0, ra, ra, rs, ~rs, we, we, wa, wa};
   endfunction

   // Starts a run and compares every cycle against the model; stop_k>0 ends early without summary checks.
   task automatic run_and_check(input int which, input int inject_lo, input int inject_hi, input int stop_k);
      int p, s_len, total, last, done_cnt, done_k, fall_k;
      logic [48:0] o, e;
      logic [8:0] prev_ra;
      logic prev_rd;
      logic [1:0] m4, m5, m6;
      logic [3:0] l4, l5, l6;
      p = (which != 0) ? 1 : 8;
      s_len = 513 + p;
      total = 12 * s_len + 1;
      last = (stop_k > 0) ? stop_k : total + 3;
      done_cnt = 0; done_k = -1; fall_k = -1;
      prev_ra = 0; prev_rd = 0;
      m4 = 2'd3; m5 = 2'd3; m6 = 2'd3; l4 = 0; l5 = 0; l6 = 0;
      o = '0;
      @(negedge clk);
      if (which != 0) start1 = 1; else start = 1;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         start = 0; start1 = 0;
         o = obs(which);
         e = model(k, p);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cycle_outputs dut%0d k=%0d got=%h want=%h", which, k, o, e);
         end
         if (which != 0 && o[19] === 1'b1) begin
            checks++;
            if (!prev_rd || o[17:9] !== prev_ra) begin
               errors++;
               $display("FAIL write_trails_read k=%0d got_addr=%0d prev_read=%0d prev_rd=%0b", k, o[17:9], prev_ra, prev_rd);
            end
         end
         prev_ra = o[30:22];
         prev_rd = o[48] && !o[47] && ((k - 1) % s_len) < 512;
         if (o[47] === 1'b1) begin done_cnt++; done_k = k; end
         if (fall_k < 0 && o[48] === 1'b0) fall_k = k;
         if (k == 4 * s_len + 1) begin m4 = o[42:41]; l4 = o[46:43]; end
         if (k == 5 * s_len + 1) begin m5 = o[42:41]; l5 = o[46:43]; end
         if (k == 6 * s_len + 1) begin m6 = o[42:41]; l6 = o[46:43]; end
         if (k == p + 1) begin
            checks++;
            if (o[19] !== 1'b1 || o[17:9] !== 9'd0) begin
               errors++;
               $display("FAIL first_write dut%0d k=%0d got_we=%0b got_addr=%0d want_we=1 want_addr=0", which, k, o[19], o[17:9]);
            end
         end
         if (k >= inject_lo && k <= inject_hi && $urandom_range(0, 3) == 0) begin
            if (which != 0) start1 = 1; else start = 1;
         end
      end
      start = 0; start1 = 0;
      if (stop_k <= 0) begin
         checks++;
         if (done_cnt != 1 || done_k != total) begin
            errors++;
            $display("FAIL done_pulse dut%0d got_count=%0d got_cycle=%0d want_count=1 want_cycle=%0d", which, done_cnt, done_k, total);
         end
         checks++;
         if (fall_k != total + 1) begin
            errors++;
            $display("FAIL busy_fall dut%0d got=%0d want=%0d", which, fall_k, total + 1);
         end
         checks++;
         if (l4 !== 4'd4 || m4 !== 2'd0 || l5 !== 4'd5 || m5 !== 2'd1 || l6 !== 4'd6 || m6 !== 2'd2) begin
            errors++;
            $display("FAIL mode_walk dut%0d got lm/mode %0d/%0d %0d/%0d %0d/%0d want 4/0 5/1 6/2", which, l4, m4, l5, m5, l6, m6);
         end
         checks++;
         if (o[21] !== 1'b0 || o[20] !== 1'b1) begin
            errors++;
            $display("FAIL final_banks dut%0d got rsel=%0b wsel=%0b want rsel=0 wsel=1", which, o[21], o[20]);
         end
      end
   endtask

   task automatic test_reset();
      logic [48:0] idle_v;
      idle_v = model(0, 8);
      rst_n = 0; start = 0; start1 = 0;
      #2;
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (obs(w) !== idle_v) begin
            errors++;
            $display("FAIL reset_state dut%0d got=%h want=%h", w, obs(w), idle_v);
         end
      end
      start = 1; start1 = 1;
      #30;
      checks++;
      if (obs(0) !== idle_v || obs(1) !== idle_v) begin
         errors++;
         $display("FAIL reset_held got=%h/%h want=%h", obs(0), obs(1), idle_v);
      end
      @(negedge clk);
      start = 0; start1 = 0;
      rst_n = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (obs(0) !== idle_v || obs(1) !== idle_v) begin
            errors++;
            $display("FAIL idle_after_reset k=%0d got=%h/%h want=%h", k, obs(0), obs(1), idle_v);
         end
      end
   endtask

   task automatic test_full_run();
      run_and_check(0, 0, -1, 0);
   endtask

   task automatic test_start_ignored();
      run_and_check(0, 2 * 521 + 1, 3 * 521, 0);
   endtask

   task automatic test_reset_mid_drain();
      int abort_k;
      logic [48:0] idle_v;
      idle_v = model(0, 8);
      abort_k = 3 * 521 + 1 + 512 + int'($urandom_range(0, 7));
      run_and_check(0, 0, -1, abort_k);
      #2 rst_n = 0;
      #1;
      checks++;
      if (obs(0) !== idle_v) begin
         errors++;
         $display("FAIL async_reset_mid got=%h want=%h", obs(0), idle_v);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         checks++;
         if (upper_write_enable !== 1'b0 || lower_write_enable !== 1'b0 || obs(0) !== idle_v) begin
            errors++;
            $display("FAIL no_write_after_abort k=%0d got=%h want=%h", k, obs(0), idle_v);
         end
      end
      run_and_check(0, 0, -1, 0);
   endtask

   task automatic test_pipe1();
      run_and_check(1, 1, 100, 0);
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_start_ignored();
      test_reset_mid_drain();
      test_pipe1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
